// File: rtl/dig_map_arbiter.sv
`timescale 1ns/1ps
// dig_map_arbiter
//   Owns the 40x30 dug-tunnel bitmap (one bit per 16x16 cell of the 640x480
//   playfield) held in a single-port 1200x1 store. The store is shared by
//   the background renderer (one read per 16 pixels), the digger (marks a
//   cell dug) and the monster logic (asks whether a cell is dug). A clear
//   sweep zeroes the whole map after reset or on clearLevel.
//
// Ports
//   clk, resetN           pixel clock, asynchronous active-low reset
//   pixelX, pixelY        current raster position (incl. blanking)
//   clearLevel            one-cycle pulse, restarts the clear sweep
//   busy                  high while the clear sweep runs
//   digReq/digCol/digRow  digger write request (held until granted)
//   digGrant              write performed at the end of this cycle
//   qryReq/qryCol/qryRow  monster query request (held until granted)
//   qryGrant              read issued this cycle
//   qryValid, qryDug      query result, one cycle after qryGrant
//   dugPixel              registered dug flag for the raster position
module dig_map_arbiter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        clearLevel,
  output logic        busy,
  input  logic        digReq,
  input  logic [5:0]  digCol,
  input  logic [4:0]  digRow,
  output logic        digGrant,
  input  logic        qryReq,
  input  logic [5:0]  qryCol,
  input  logic [4:0]  qryRow,
  output logic        qryGrant,
  output logic        qryValid,
  output logic        qryDug,
  output logic        dugPixel
);

  localparam int CELLS = 1200;
  localparam int VIS_W = 640;
  localparam int VIS_H = 480;
  localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;

  // row*40 + col, computed as (row<<5)+(row<<3)+col
  function automatic logic [10:0] cell_addr(input logic [10:0] row,
                                            input logic [10:0] col);
    return (row << 5) + (row << 3) + col;
  endfunction

  // ---------------------------------------------------------------------
  // Render slot: fetch the cell the raster enters next.
  // ---------------------------------------------------------------------
  logic [10:0] x_next;
  logic [10:0] y_next;
  logic        slot_mid;
  logic        slot_eol;
  logic        slot;
  logic [10:0] slot_addr;
  logic        pix_vis;

  always_comb begin
    x_next    = pixelX + 11'd1;
    y_next    = (pixelY == 11'(V_TOTAL - 1)) ? '0 : pixelY + 11'd1;
    slot_mid  = (pixelX[3:0] == 4'hF) && (pixelX < 11'(VIS_W - 1)) &&
                (pixelY < 11'(VIS_H));
    slot_eol  = (pixelX == 11'(H_TOTAL - 1)) && (y_next < 11'(VIS_H));
    slot      = (state_q == S_RUN) && (slot_mid || slot_eol);
    slot_addr = slot_eol ? cell_addr(y_next >> 4, '0)
                         : cell_addr(pixelY >> 4, x_next >> 4);
    pix_vis   = (pixelX < 11'(VIS_W)) && (pixelY < 11'(VIS_H));
  end

  // ---------------------------------------------------------------------
  // Requester arbitration
  // ---------------------------------------------------------------------
  logic        favor_qry_q;
  logic        dig_oor;
  logic        qry_oor;
  logic [10:0] dig_addr;
  logic [10:0] qry_addr;
  logic        free_slot;

  always_comb begin
    dig_oor   = (digCol >= 6'd40) || (digRow >= 5'd30);
    qry_oor   = (qryCol >= 6'd40) || (qryRow >= 5'd30);
    dig_addr  = cell_addr({6'b0, digRow}, {5'b0, digCol});
    qry_addr  = cell_addr({6'b0, qryRow}, {5'b0, qryCol});
    free_slot = (state_q == S_RUN) && !slot;
    digGrant  = free_slot && digReq && (!qryReq || !favor_qry_q);
    qryGrant  = free_slot && qryReq && (!digReq || favor_qry_q);
    busy      = (state_q == S_CLEAR);
  end

  // ---------------------------------------------------------------------
  // Store port: exactly one access per cycle
  // ---------------------------------------------------------------------
  logic        mem [CELLS];
  logic        mem_we;
  logic        mem_wdata;
  logic [10:0] mem_addr;

  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = 1'b0;
    mem_addr  = qry_addr;
    if (state_q == S_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt_q;
    end else if (slot) begin
      mem_addr = slot_addr;
    end else if (digGrant && !dig_oor) begin
      mem_we    = 1'b1;
      mem_wdata = 1'b1;
      mem_addr  = dig_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 11'd1;
      if (clr_cnt_q == LAST_CELL) begin
        state_d   = S_RUN;
        clr_cnt_d = '0;
      end
    end
    if (clearLevel) begin
      state_d   = S_CLEAR;
      clr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Read data registers. The single read port feeds two enabled holding
  // registers so a query read never disturbs the cell being displayed.
  // dugPixel is one cycle behind the raster: the slot result lands in
  // slot_data_q while the cell's first pixel is on pixelX, and dugPixel
  // follows on the next cycle.
  // ---------------------------------------------------------------------
  logic slot_data_q;
  logic qry_valid_q;
  logic qry_dug_q;
  logic dug_pixel_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      favor_qry_q <= 1'b0;
      slot_data_q <= 1'b0;
      qry_valid_q <= 1'b0;
      qry_dug_q   <= 1'b0;
      dug_pixel_q <= 1'b0;
    end else begin
      if (digGrant)      favor_qry_q <= 1'b1;
      else if (qryGrant) favor_qry_q <= 1'b0;
      if (slot) slot_data_q <= mem[mem_addr];
      qry_valid_q <= qryGrant;
      if (qryGrant) qry_dug_q <= qry_oor ? 1'b0 : mem[mem_addr];
      dug_pixel_q <= (state_q == S_RUN) && pix_vis && slot_data_q;
    end
  end

  assign qryValid = qry_valid_q;
  assign qryDug   = qry_dug_q;
  assign dugPixel = dug_pixel_q;

endmodule

// File: tb/tb_dig_map_arbiter.sv
`timescale 1ns/1ps
module tb_dig_map_arbiter;

  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        clearLevel;
  logic        busy;
  logic        digReq;
  logic [5:0]  digCol;
  logic [4:0]  digRow;
  logic        digGrant;
  logic        qryReq;
  logic [5:0]  qryCol;
  logic [4:0]  qryRow;
  logic        qryGrant;
  logic        qryValid;
  logic        qryDug;
  logic        dugPixel;

  always #5 clk = ~clk;

  dig_map_arbiter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .clearLevel(clearLevel), .busy(busy),
    .digReq(digReq), .digCol(digCol), .digRow(digRow), .digGrant(digGrant),
    .qryReq(qryReq), .qryCol(qryCol), .qryRow(qryRow), .qryGrant(qryGrant),
    .qryValid(qryValid), .qryDug(qryDug), .dugPixel(dugPixel)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit map [30][40];
  int clear_left;
  bit fav_qry;
  bit exp_qvalid, exp_qdug;
  bit last_dg, last_qg;
  int px, py;
  bit chk_pix;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)",
               tag, act, exp, px, py, $time);
    end
  endtask

  function automatic bit is_slot(input int x, input int y);
    int yn;
    yn = (y + 1) % V_TOTAL;
    return ((x % 16 == 15) && (x < 639) && (y < 480)) ||
           ((x == H_TOTAL - 1) && (yn < 480));
  endfunction

  task automatic clear_map();
    foreach (map[r, c]) map[r][c] = 1'b0;
  endtask

  // One clock cycle: drive raster, check grants mid-cycle, advance model,
  // check registered outputs just after the edge.
  task automatic step();
    bit in_run, slot, eg_d, eg_q, vis, dug_exp;
    int dc, dr, qc, qr;
    pixelX = 11'(px);
    pixelY = 11'(py);
    #4;
    in_run = (clear_left == 0);
    slot   = is_slot(px, py);
    eg_d   = in_run && !slot && digReq && (!qryReq || !fav_qry);
    eg_q   = in_run && !slot && qryReq && (!digReq || fav_qry);
    check("digGrant", 32'(digGrant), 32'(eg_d));
    check("qryGrant", 32'(qryGrant), 32'(eg_q));
    vis = (px < 640) && (py < 480);
    dug_exp = 1'b0;
    if (in_run && vis) dug_exp = map[py / 16][px / 16];
    dc = int'(digCol); dr = int'(digRow);
    qc = int'(qryCol); qr = int'(qryRow);
    exp_qvalid = eg_q;
    if (eg_q) begin
      exp_qdug = (qc < 40 && qr < 30) ? map[qr][qc] : 1'b0;
      fav_qry  = 1'b0;
    end
    if (eg_d) begin
      fav_qry = 1'b1;
      if (dc < 40 && dr < 30) map[dr][dc] = 1'b1;
    end
    if (clearLevel) begin
      clear_left = 1200;
      clear_map();
    end else if (clear_left > 0) begin
      clear_left--;
    end
    last_dg = eg_d;
    last_qg = eg_q;
    @(posedge clk);
    #1;
    check("busy", 32'(busy), 32'(clear_left > 0));
    check("qryValid", 32'(qryValid), 32'(exp_qvalid));
    check("qryDug", 32'(qryDug), 32'(exp_qdug));
    if (!(in_run && vis) || chk_pix)
      check("dugPixel", 32'(dugPixel), 32'(dug_exp));
    px++;
    if (px == H_TOTAL) begin
      px = 0;
      py = (py + 1) % V_TOTAL;
    end
  endtask

  task automatic do_dig(input int c, input int r);
    bit got;
    got = 1'b0;
    digCol = 6'(c);
    digRow = 5'(r);
    digReq = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = last_dg;
    end
    digReq = 1'b0;
    check("dig_wait", 32'(digGrant | got), 32'd1);
  endtask

  task automatic do_query(input int c, input int r, input bit exp);
    bit got;
    got = 1'b0;
    qryCol = 6'(c);
    qryRow = 5'(r);
    qryReq = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = last_qg;
    end
    qryReq = 1'b0;
    check("qry_wait", 32'(qryValid), 32'(got));
    check("qry_result", 32'(qryDug), 32'(exp));
  endtask

  task automatic sweep(input int y0, input int nlines);
    digReq  = 1'b0;
    qryReq  = 1'b0;
    px      = 0;
    py      = y0;
    chk_pix = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      for (int x = 0; x < H_TOTAL; x++) step();
      chk_pix = 1'b1;
    end
    chk_pix = 1'b0;
  endtask

  task automatic wait_clear_done(input string tag);
    int busy_cycles;
    busy_cycles = 0;
    for (int i = 0; i < 1300 && busy; i++) begin
      busy_cycles++;
      digCol = 6'($urandom_range(0, 39));
      qryCol = 6'($urandom_range(0, 39));
      step();
    end
    check(tag, 32'(busy_cycles), 32'd1200);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; clearLevel = 1'b0;
    digReq = 1'b1; digCol = 6'd1; digRow = 5'd1;
    qryReq = 1'b1; qryCol = 6'd2; qryRow = 5'd2;
    px = 0; py = 0; chk_pix = 1'b0;
    pixelX = '0; pixelY = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_digGrant", 32'(digGrant), 32'd0);
    check("rst_qryGrant", 32'(qryGrant), 32'd0);
    check("rst_qryValid", 32'(qryValid), 32'd0);
    check("rst_qryDug", 32'(qryDug), 32'd0);
    check("rst_dugPixel", 32'(dugPixel), 32'd0);
    resetN = 1'b1;
    clear_left = 1200; fav_qry = 1'b0;
    exp_qvalid = 1'b0; exp_qdug = 1'b0;
    clear_map();

    // Requests held through the power-up clear are ignored
    wait_clear_done("busy_len_reset");
    digReq = 1'b0;
    qryReq = 1'b0;

    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++) do_query(c, r, 1'b0);

    do_dig(5, 3);
    do_query(5, 3, 1'b1);
    do_query(5, 4, 1'b0);
    do_dig(39, 29);
    do_dig(40, 0);
    do_query(40, 0, 1'b0);
    do_query(0, 1, 1'b0);
    do_query(39, 29, 1'b1);

    // Contention through a full line
    px = 0; py = 100;
    digReq = 1'b1; qryReq = 1'b1;
    for (int i = 0; i < H_TOTAL; i++) begin
      digCol = 6'($urandom_range(0, 39)); digRow = 5'($urandom_range(0, 29));
      qryCol = 6'($urandom_range(0, 45)); qryRow = 5'($urandom_range(0, 31));
      step();
    end
    digReq = 1'b0; qryReq = 1'b0;

    // Random traffic, including out-of-range cells
    for (int i = 0; i < 1500; i++) begin
      if (!digReq || last_dg) begin
        digReq = ($urandom_range(0, 2) == 0);
        digCol = 6'($urandom_range(0, 44));
        digRow = 5'($urandom_range(0, 31));
      end
      if (!qryReq || last_qg) begin
        qryReq = ($urandom_range(0, 1) == 0);
        qryCol = 6'($urandom_range(0, 44));
        qryRow = 5'($urandom_range(0, 31));
      end
      step();
    end
    digReq = 1'b0; qryReq = 1'b0;

    sweep(46, 20);
    sweep(462, 20);
    sweep(524, 6);

    // clearLevel coinciding with a query grant: result still delivered
    px = 0; py = 200;
    qryCol = 6'd5; qryRow = 5'd3; qryReq = 1'b1;
    clearLevel = 1'b1;
    step();
    clearLevel = 1'b0;
    check("clr_qry_valid", 32'(qryValid), 32'd1);
    check("clr_qry_dug", 32'(qryDug), 32'd1);
    digReq = 1'b1;
    for (int i = 0; i < 600; i++) step();
    clearLevel = 1'b1;
    step();
    clearLevel = 1'b0;
    wait_clear_done("busy_len_restart");
    digReq = 1'b0; qryReq = 1'b0;

    do_query(5, 3, 1'b0);
    do_query(39, 29, 1'b0);
    for (int i = 0; i < 100; i++)
      do_query($urandom_range(0, 39), $urandom_range(0, 29), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
